// File: rtl/noc_pkg.sv
// Shared mesh-router constants, port codes and switch-allocator state type.
package noc_pkg;

    localparam int NPORTS = 5;
    localparam int PW     = 3;

    localparam logic [PW-1:0] PORT_E     = 3'd0;
    localparam logic [PW-1:0] PORT_W     = 3'd1;
    localparam logic [PW-1:0] PORT_N     = 3'd2;
    localparam logic [PW-1:0] PORT_S     = 3'd3;
    localparam logic [PW-1:0] PORT_LOCAL = 3'd4;

    typedef enum logic {
        OS_IDLE,
        OS_LOCKED
    } out_state_e;

    // Round-robin successor of a port index, wrapping Inject/Eject back to East.
    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (p >= PORT_LOCAL) ? PORT_E : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// Combinational 5-way round-robin picker: first set request scanning from ptr upward, modulo 5.
module rr_arb5
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NPORTS-1:0] gnt,
    output logic              valid
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = PW'((int'(ptr) + k) % NPORTS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/sw_alloc_rr.sv
// Round-robin switch allocator with per-output wormhole locking for the 5-port mesh router.
module sw_alloc_rr
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS*PW-1:0] req_out,
    input  logic [NPORTS-1:0]    req_tail,
    input  logic [NPORTS-1:0]    out_en,
    output logic [NPORTS-1:0]    grant,
    output logic [NPORTS*PW-1:0] xbar_sel,
    output logic [NPORTS-1:0]    xbar_vld,
    output logic [NPORTS-1:0]    busy
);

    out_state_e        state_q [NPORTS];
    out_state_e        state_d [NPORTS];
    logic [PW-1:0]     owner_q [NPORTS];
    logic [PW-1:0]     owner_d [NPORTS];
    logic [PW-1:0]     ptr_q   [NPORTS];
    logic [PW-1:0]     ptr_d   [NPORTS];

    logic [NPORTS-1:0] locked_by [NPORTS];
    logic [NPORTS-1:0] arb_req   [NPORTS];
    logic [NPORTS-1:0] arb_gnt   [NPORTS];
    logic [NPORTS-1:0] arb_vld;

    logic [NPORTS-1:0]    grant_d;
    logic [NPORTS*PW-1:0] sel_d;
    logic [NPORTS-1:0]    vld_d;
    logic [NPORTS-1:0]    busy_d;

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                locked_by[o][i] = (state_q[o] == OS_LOCKED) && (owner_q[o] == PW'(i));
            end
        end
    end

    // A head that just won is masked for one cycle since grant has not yet popped it upstream.
    logic other_lock;
    always_comb begin
        other_lock = 1'b0;
        for (int o = 0; o < NPORTS; o++) begin
            arb_req[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                other_lock = 1'b0;
                for (int o2 = 0; o2 < NPORTS; o2++) begin
                    if (o2 != o && locked_by[o2][i]) begin
                        other_lock = 1'b1;
                    end
                end
                arb_req[o][i] = req[i] && (req_out[i*PW +: PW] == PW'(o)) && !grant[i]
                                && !other_lock
                                && ((state_q[o] == OS_IDLE) || locked_by[o][i]);
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arb5 u_arb (
            .req   (arb_req[o]),
            .ptr   (ptr_q[o]),
            .gnt   (arb_gnt[o]),
            .valid (arb_vld[o])
        );
    end

    logic [PW-1:0] win;
    always_comb begin
        grant_d = '0;
        sel_d   = '0;
        vld_d   = '0;
        busy_d  = '0;
        win     = '0;
        for (int o = 0; o < NPORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            win        = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (arb_gnt[o][i]) begin
                    win = PW'(i);
                end
            end
            if (arb_vld[o] && out_en[o]) begin
                grant_d              = grant_d | arb_gnt[o];
                sel_d[o*PW +: PW]    = win;
                vld_d[o]             = 1'b1;
                if (|(arb_gnt[o] & req_tail)) begin
                    state_d[o] = OS_IDLE;
                    ptr_d[o]   = next_port(win);
                end else begin
                    state_d[o] = OS_LOCKED;
                    owner_d[o] = win;
                end
            end
            busy_d[o] = (state_d[o] == OS_LOCKED);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= OS_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            grant    <= '0;
            xbar_sel <= '0;
            xbar_vld <= '0;
            busy     <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            grant    <= grant_d;
            xbar_sel <= sel_d;
            xbar_vld <= vld_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Directed and random checks of sw_alloc_rr against a packet-level reference model.
module tb_sw_alloc_rr;
    import noc_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NPORTS-1:0]    req;
    logic [NPORTS*PW-1:0] req_out;
    logic [NPORTS-1:0]    req_tail;
    logic [NPORTS-1:0]    out_en;
    logic [NPORTS-1:0]    grant;
    logic [NPORTS*PW-1:0] xbar_sel;
    logic [NPORTS-1:0]    xbar_vld;
    logic [NPORTS-1:0]    busy;

    int total = 0;
    int bad   = 0;

    // Model state: owner per output (-1 = free), pointer per output, predicted registered outputs.
    int                   m_owner [NPORTS];
    int                   m_ptr   [NPORTS];
    int                   snap    [NPORTS];
    logic [NPORTS-1:0]    m_grant;
    logic [NPORTS*PW-1:0] m_sel;
    logic [NPORTS-1:0]    m_vld;
    logic [NPORTS-1:0]    m_busy;

    sw_alloc_rr dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_out  (req_out),
        .req_tail (req_tail),
        .out_en   (out_en),
        .grant    (grant),
        .xbar_sel (xbar_sel),
        .xbar_vld (xbar_vld),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NPORTS*PW-1:0] codes(input int c0, input int c1, input int c2,
                                                   input int c3, input int c4);
        return {PW'(c4), PW'(c3), PW'(c2), PW'(c1), PW'(c0)};
    endfunction

    task automatic applyStimulus(input logic [NPORTS-1:0] r, input logic [NPORTS*PW-1:0] ro,
                                 input logic [NPORTS-1:0] t, input logic [NPORTS-1:0] e,
                                 input logic rst_n);
        req      = r;
        req_out  = ro;
        req_tail = t;
        out_en   = e;
        reset    = rst_n;
    endtask

    function automatic bit eligible(input int i, input int o);
        if (!req[i] || int'(req_out[i*PW +: PW]) != o || m_grant[i]) return 0;
        if (snap[o] != -1 && snap[o] != i) return 0;
        for (int o2 = 0; o2 < NPORTS; o2++)
            if (o2 != o && snap[o2] == i) return 0;
        return 1;
    endfunction

    task automatic modelStep();
        logic [NPORTS-1:0]    g;
        logic [NPORTS*PW-1:0] s;
        logic [NPORTS-1:0]    v;
        if (!reset) begin
            for (int o = 0; o < NPORTS; o++) begin
                m_owner[o] = -1;
                m_ptr[o]   = 0;
            end
            m_grant = '0; m_sel = '0; m_vld = '0; m_busy = '0;
            return;
        end
        for (int o = 0; o < NPORTS; o++) snap[o] = m_owner[o];
        g = '0; s = '0; v = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (out_en[o]) begin
                for (int k = 0; k < NPORTS; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % NPORTS;
                    if (v[o] == 1'b0 && eligible(i, o)) begin
                        g[i] = 1'b1;
                        s[o*PW +: PW] = PW'(i);
                        v[o] = 1'b1;
                        if (req_tail[i]) begin
                            m_owner[o] = -1;
                            m_ptr[o]   = (i + 1) % NPORTS;
                        end else begin
                            m_owner[o] = i;
                        end
                    end
                end
            end
        end
        m_grant = g; m_sel = s; m_vld = v;
        for (int o = 0; o < NPORTS; o++) m_busy[o] = (m_owner[o] != -1);
    endtask

    task automatic checkOutput();
        chk("grant",    16'(grant),    16'(m_grant));
        chk("xbar_sel", 16'(xbar_sel), 16'(m_sel));
        chk("xbar_vld", 16'(xbar_vld), 16'(m_vld));
        chk("busy",     16'(busy),     16'(m_busy));
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus('0, '0, '0, '1, 1'b0);
        tick();
        tick();
    endtask

    int order[$];
    int w_left;
    int s_early;
    int s_granted;

    initial begin
        for (int o = 0; o < NPORTS; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end
        m_grant = '0; m_sel = '0; m_vld = '0; m_busy = '0;

        // Reset state
        doReset();
        chk("reset_grant", 16'(grant), 16'h0);
        chk("reset_busy",  16'(busy),  16'h0);

        // Single winner: E and N both to Eject with single-flit packets
        applyStimulus(5'b00101, codes(4, 0, 4, 0, 0), 5'b11111, 5'b11111, 1'b1);
        tick();
        chk("single_first", 16'(grant), 16'h01);
        chk("single_sel4",  16'(xbar_sel[4*PW +: PW]), 16'h0);
        tick();
        chk("single_second", 16'(grant), 16'h04);
        chk("single_sel4b",  16'(xbar_sel[4*PW +: PW]), 16'h2);

        // Fairness: everyone hammers output 0
        doReset();
        applyStimulus(5'b11111, codes(0, 0, 0, 0, 0), 5'b11111, 5'b11111, 1'b1);
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < NPORTS; i++)
                if (grant[i]) order.push_back(i);
        end
        chk("fair_count", 16'(order.size() >= 10), 16'h1);
        for (int k = 0; k < 10 && k < order.size(); k++)
            chk("fair_order", 16'(order[k]), 16'(k % NPORTS));

        // Wormhole: W sends 3 flits to N while S also wants N
        doReset();
        w_left = 3; s_early = 0; s_granted = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus({1'b0, (s_granted == 0), 1'b0, (w_left > 0), 1'b0},
                          codes(0, 2, 0, 2, 0),
                          {3'b010, (w_left == 1), 1'b0}, 5'b11111, 1'b1);
            tick();
            if (grant[3]) begin
                if (w_left > 0) s_early++;
                s_granted++;
            end
            if (grant[1]) begin
                w_left--;
                chk("worm_busy", 16'(busy[2]), 16'(w_left > 0));
            end
        end
        chk("worm_w_done",  16'(w_left), 16'h0);
        chk("worm_s_early", 16'(s_early), 16'h0);
        chk("worm_s_once",  16'(s_granted), 16'h1);

        // Backpressure: output 0 locked to input 2, then stalled
        doReset();
        applyStimulus(5'b00100, codes(0, 0, 0, 0, 0), 5'b00000, 5'b11111, 1'b1);
        tick();
        chk("bp_head", 16'(grant), 16'h04);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(5'b00100, codes(0, 0, 0, 0, 0), 5'b00100, 5'b11110, 1'b1);
            tick();
            chk("bp_nogrant", 16'(grant), 16'h0);
            chk("bp_busy",    16'(busy[0]), 16'h1);
        end
        applyStimulus(5'b00100, codes(0, 0, 0, 0, 0), 5'b00100, 5'b11111, 1'b1);
        tick();
        chk("bp_resume", 16'(grant), 16'h04);
        chk("bp_free",   16'(busy[0]), 16'h0);

        // Parallel transfers plus an invalid output code
        doReset();
        applyStimulus(5'b10101, codes(1, 0, 3, 0, 6), 5'b11111, 5'b11111, 1'b1);
        tick();
        chk("par_grant", 16'(grant), 16'h05);
        tick();
        tick();
        chk("invalid_never", 16'(grant[4]), 16'h0);

        // Reset while output 3 is mid-packet
        doReset();
        applyStimulus(5'b00001, codes(3, 0, 0, 0, 0), 5'b00000, 5'b11111, 1'b1);
        tick();
        chk("rst_lock", 16'(busy[3]), 16'h1);
        applyStimulus(5'b00001, codes(3, 0, 0, 0, 0), 5'b00000, 5'b11111, 1'b0);
        tick();
        chk("rst_busy",  16'(busy), 16'h0);
        chk("rst_vld",   16'(xbar_vld), 16'h0);
        applyStimulus(5'b00110, codes(0, 3, 3, 0, 0), 5'b11111, 5'b11111, 1'b1);
        tick();
        chk("rst_after", 16'(grant), 16'h02);

        // Random traffic with occasional resets
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(NPORTS'($urandom),
                          codes($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                $urandom_range(0, 7), $urandom_range(0, 7)),
                          NPORTS'($urandom),
                          NPORTS'($urandom) | NPORTS'($urandom),
                          ($urandom_range(0, 59) != 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_alloc_rr.md
# sw_alloc_rr

Round-robin switch allocator with wormhole output locking for the 5-port mesh router (E, W, N, S, Inject/Eject). Each input whose VC is allocated requests one output port. Per output, the block grants one requester per transfer and keeps the output locked to that input until its tail flit is granted. It drives the crossbar select lines and the per-input flit acks, and replaces fixed-priority switch-traversal control with fair, packet-atomic arbitration.

## Interface
- NPORTS, 5, number of router ports; index/code 0=E, 1=W, 2=N, 3=S, 4=Inject (input side) / Eject (output side)
- PW, 3, width of a port code
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on rising clk
- req  in  NPORTS  req[i]=1: input i holds a VC-allocated flit at its buffer head
- req_out  in  NPORTS*PW  bits [i*PW +: PW]: output code requested by input i; codes 5–7 invalid and ignored
- req_tail  in  NPORTS  flit at input i is a tail (single-flit packets assert it too)
- out_en  in  NPORTS  output o can accept a flit this cycle (downstream credit/ready)
- grant  out  NPORTS  registered one-cycle pulse: input i's head flit is transferred; upstream pops on it
- xbar_sel  out  NPORTS*PW  bits [o*PW +: PW]: input index driving output o
- xbar_vld  out  NPORTS  output o carries a valid flit this cycle
- busy  out  NPORTS  output o is locked mid-packet

## Operation
- Each output o has a two-state FSM: IDLE, or LOCKED(owner). It also keeps a round-robin pointer rr_ptr[o] in 0..4.
- Eligible input i for output o: req[i]=1, req_out[i]==o, grant[i]=0 in the current cycle (stale-request mask), and input i does not own a different locked output.
- IDLE, out_en[o]=1, any eligible input: pick the first eligible input scanning rr_ptr[o], rr_ptr[o]+1, … mod 5.
  - Winner w, tail: stay IDLE and set rr_ptr[o] ← (w+1) mod 5.
  - Winner w, non-tail: go to LOCKED(w); rr_ptr is unchanged.
- LOCKED(w): only w is eligible.
  - If w is eligible and out_en[o]=1: grant.
  - If that flit is tail: go to IDLE and set rr_ptr[o] ← (w+1) mod 5.
  - Otherwise hold with no grant; the lock is never dropped by out_en=0 or req=0.
- A grant to w on output o sets next-cycle grant[w]=1, xbar_sel[o]=w and xbar_vld[o]=1.
- Outputs with no grant drive xbar_vld[o]=0 and xbar_sel[o]=0.
- Each input requests one output, so grant is one-hot per output and at most one output per input.
- busy[o] = (state is LOCKED), registered.
- Requests with an invalid code never match any output and never grant.

## Timing
- Grant latency is 1 cycle: request/out_en sampled at edge t, so grant/xbar_sel/xbar_vld are high during cycle t+1 only.
- Throughput per input is one flit per 2 cycles, because the grant-cycle mask ignores the stale head. Different inputs to different outputs grant in the same cycle.
- Per output, back-to-back grants to different inputs are possible with single-flit packets.
- Tail grant at edge t frees the output. A new head is arbitrated at edge t+1 with the updated rr_ptr.
- Reset (reset=0 at an edge):
  - grant, xbar_sel, xbar_vld and busy all become 0.
  - All FSMs go to IDLE and all rr_ptr to 0.
  - In-flight locks are discarded without a tail.
- Reset takes priority over any simultaneous request.

## Structure
- Shared package noc_pkg holds:
  - constants NPORTS=5, PW=3;
  - port codes PORT_E=0, PORT_W=1, PORT_N=2, PORT_S=3, PORT_LOCAL=4;
  - the out-FSM state enum {OS_IDLE, OS_LOCKED}.
- Sub-module rr_arb5: combinational 5-way round-robin picker (inputs req[4:0] and ptr[2:0]; outputs a one-hot grant and a valid). It is instantiated once per output.
- Top module holds per-output state/owner/rr_ptr registers, the eligibility masks and the output registers.

## Test plan
- Single winner: E(0) and N(2) both request output 4 (Eject) with tail=1, out_en=5'b11111 → cycle+1 grant=00001 (bit 0 = E), xbar_sel[4]=0. Next eligible cycle grants N (grant=00100, bit 2) with rr_ptr[4]=1.
- Fairness: inputs 0–4 all request output 0 with single-flit packets and hold → grants rotate 0, 1, 2, 3, 4, 0, each input once per 5 grants.
- Wormhole lock: W(1) sends a 3-flit packet to N while S(3) also requests N.
  - All three W flits are granted before any S grant.
  - busy[2]=1 from after the head until after the tail.
  - S is granted after the tail.
- Backpressure: output 0 locked to input 2 and out_en[0]=0 for 4 cycles → no grant, busy[0] stays 1. A grant follows 1 cycle after out_en returns to 1.
- Parallel and invalid: E→W and N→S simultaneously → both granted in the same cycle. An input with req_out=6 is never granted.
- Reset mid-packet: reset=0 while output 3 is locked → next cycle all outputs are 0 and busy=0. After release, a new head from a different input is granted with rr_ptr=0 ordering.
